// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the decode stage.
// Two write ports (port 1 wins on an address collision), RD_PORTS
// combinational read ports, and a per-register busy scoreboard that marks
// registers with a pending writeback. Register 0 is hardwired to zero.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read bypass).
module regfile_mp #(
  parameter int              WIDTH      = 32,
  parameter int              ADDR_WIDTH = 5,
  parameter int              NUM        = 32,
  parameter int              RD_PORTS   = 2,
  parameter logic [WIDTH-1:0] GP_INIT   = 32'h00001800,
  parameter logic [WIDTH-1:0] SP_INIT   = 32'h00002ffe
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [RD_PORTS*WIDTH-1:0]      rdata,
  output logic [RD_PORTS-1:0]            rbusy,
  input  logic                           we0,
  input  logic [ADDR_WIDTH-1:0]          wa0,
  input  logic [WIDTH-1:0]               wd0,
  input  logic                           we1,
  input  logic [ADDR_WIDTH-1:0]          wa1,
  input  logic [WIDTH-1:0]               wd1,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  output logic [NUM-1:0]                 busy_vec
);

  // Architectural reset value of register idx (gp and sp are preset).
  function automatic logic [WIDTH-1:0] init_value(input int idx);
    logic [WIDTH-1:0] v;
    if (idx == 28) begin
      v = GP_INIT;
    end else if (idx == 29) begin
      v = SP_INIT;
    end else begin
      v = {WIDTH{1'b0}};
    end
    return v;
  endfunction

  // True for an address that names a real, writable register (not r0,
  // not beyond NUM). Reads and writes outside this set are inert.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != {ADDR_WIDTH{1'b0}}) && (32'(a) < NUM);
  endfunction

  logic [WIDTH-1:0] regs_q [NUM];
  logic [WIDTH-1:0] regs_d [NUM];
  logic [NUM-1:0]   busy_q;
  logic [NUM-1:0]   busy_d;

  // Next-state: writes (port 1 applied last so it wins), then issue,
  // which overrides a same-edge write clear because it is a new producer.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we0 && addr_ok(wa0)) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (we1 && addr_ok(wa1)) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_en && addr_ok(iss_addr)) begin
      busy_d[iss_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    regs_d[0] = {WIDTH{1'b0}};
    busy_d[0] = 1'b0;
  end

  // State registers; async reset restores architectural initial values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        regs_q[i] <= init_value(i);
      end
      busy_q <= {NUM{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra_s;
    logic [WIDTH-1:0]      rd_s;
    logic                  rb_s;

    assign ra_s = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Combinational read of one port; r0 and out-of-range read as idle zero.
    always_comb begin
      rd_s = {WIDTH{1'b0}};
      rb_s = 1'b0;
      if (addr_ok(ra_s)) begin
`ifdef RF_BYPASS_EN
        // A write landing this edge makes the old busy bit stale, so the
        // bypassed value is reported ready even if a new issue is pending.
        if (we1 && (wa1 == ra_s)) begin
          rd_s = wd1;
          rb_s = 1'b0;
        end else if (we0 && (wa0 == ra_s)) begin
          rd_s = wd0;
          rb_s = 1'b0;
        end else begin
          rd_s = regs_q[ra_s];
          rb_s = busy_q[ra_s];
        end
`else
        rd_s = regs_q[ra_s];
        rb_s = busy_q[ra_s];
`endif
      end else begin
        rd_s = {WIDTH{1'b0}};
        rb_s = 1'b0;
      end
    end

    assign rdata[i*WIDTH +: WIDTH] = rd_s;
    assign rbusy[i]                = rb_s;
  end

endmodule
